// File: rtl/vga_draw_arbiter_pkg.sv
// Shared types and constants for the VGA draw arbiter and the navigation logic.
package vga_draw_arbiter_pkg;

    localparam int unsigned X_W     = 8;
    localparam int unsigned Y_W     = 7;
    localparam int unsigned TIMER_W = 15;

    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] S_START  = 2'd1;
    localparam logic [STATE_W-1:0] S_DRAW   = 2'd2;
    localparam logic [STATE_W-1:0] S_FINISH = 2'd3;

    // Screen locations shared with the navigation FSM.
    localparam int unsigned LOC_W = 2;
    localparam logic [LOC_W-1:0] LOC_ROOT   = 2'd0;
    localparam logic [LOC_W-1:0] LOC_HOME   = 2'd1;
    localparam logic [LOC_W-1:0] LOC_ARCADE = 2'd2;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pixel_pos_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_draw_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request after the last owner.
module vga_draw_arbiter_rr_picker #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        // Scan last+1 .. last+N, wrapping, so the previous owner is checked last.
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDX_W'((32'(last) + k) % N);
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                winner[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the vga_adapter pixel port for N draw modules.
// Optional idle-pixel watchdog enabled by defining ARB_TIMEOUT_EN.
module vga_draw_arbiter
    import vga_draw_arbiter_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned COLOUR_W    = 9,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [N-1:0]          req,
    output logic [N-1:0]          start,
    input  logic [N*X_W-1:0]      x_in,
    input  logic [N*Y_W-1:0]      y_in,
    input  logic [N*COLOUR_W-1:0] c_in,
    input  logic [N-1:0]          plot_in,
    input  logic [N-1:0]          done_in,
    output logic [X_W-1:0]        x,
    output logic [Y_W-1:0]        y,
    output logic [COLOUR_W-1:0]   colour,
    output logic                  plot,
    output logic [N-1:0]          grant,
    output logic                  busy,
    output logic                  job_done,
    output logic                  timeout
);

    localparam int unsigned IDX_W = idx_width(N);

    logic [STATE_W-1:0]  state, state_d;
    logic [IDX_W-1:0]    owner, owner_d;
    logic [IDX_W-1:0]    last_ptr, last_ptr_d;
    logic [N-1:0]        start_d, grant_d;
    logic                busy_d, job_done_d, timeout_d, plot_d;
    logic [X_W-1:0]      x_d;
    logic [Y_W-1:0]      y_d;
    logic [COLOUR_W-1:0] colour_d;

    logic [N-1:0]        pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;

    logic [X_W-1:0]      x_arr [N];
    logic [Y_W-1:0]      y_arr [N];
    logic [COLOUR_W-1:0] c_arr [N];

    vga_draw_arbiter_rr_picker #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (req),
        .last   (last_ptr),
        .winner (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Unpack the per-module pixel buses so the owner can index them directly.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            x_arr[i] = x_in[i*X_W +: X_W];
            y_arr[i] = y_in[i*Y_W +: Y_W];
            c_arr[i] = c_in[i*COLOUR_W +: COLOUR_W];
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [TIMER_W-1:0] idle_cnt, idle_cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

    always_comb begin
        state_d    = state;
        owner_d    = owner;
        last_ptr_d = last_ptr;
        start_d    = '0;
        grant_d    = grant;
        busy_d     = busy;
        job_done_d = 1'b0;
        timeout_d  = 1'b0;
        plot_d     = 1'b0;
        x_d        = x;
        y_d        = y;
        colour_d   = colour;
`ifdef ARB_TIMEOUT_EN
        idle_cnt_d = idle_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_START;
                    owner_d = pick_idx;
                    grant_d = pick_onehot;
                    start_d = pick_onehot;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                state_d = S_DRAW;
`ifdef ARB_TIMEOUT_EN
                idle_cnt_d = '0;
`endif
            end
            S_DRAW: begin
                x_d      = x_arr[owner];
                y_d      = y_arr[owner];
                colour_d = c_arr[owner];
                plot_d   = plot_in[owner];
                if (done_in[owner]) begin
                    state_d    = S_FINISH;
                    grant_d    = '0;
                    job_done_d = 1'b1;
                    last_ptr_d = owner;
                end
`ifdef ARB_TIMEOUT_EN
                else if (plot_in[owner]) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt == TIMER_W'(TIMEOUT_CYC - 1)) begin
                    state_d    = S_FINISH;
                    grant_d    = '0;
                    job_done_d = 1'b1;
                    timeout_d  = 1'b1;
                    last_ptr_d = owner;
                end else begin
                    idle_cnt_d = idle_cnt + TIMER_W'(1);
                end
`endif
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            owner    <= '0;
            last_ptr <= IDX_W'(N - 1);
            start    <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            job_done <= 1'b0;
            timeout  <= 1'b0;
            plot     <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
        end else begin
            state    <= state_d;
            owner    <= owner_d;
            last_ptr <= last_ptr_d;
            start    <= start_d;
            grant    <= grant_d;
            busy     <= busy_d;
            job_done <= job_done_d;
            timeout  <= timeout_d;
            plot     <= plot_d;
            x        <= x_d;
            y        <= y_d;
            colour   <= colour_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter (N=4, COLOUR_W=9, TIMEOUT_CYC=16).
module tb_vga_draw_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 9;

    logic          clk = 1'b0;
    logic          resetn;
    logic [N-1:0]  req, start, plot_in, done_in, grant;
    logic [N*8-1:0]  x_in;
    logic [N*7-1:0]  y_in;
    logic [N*CW-1:0] c_in;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [CW-1:0] colour;
    logic          plot, busy, job_done, timeout;

    int n_checks = 0;
    int n_fail   = 0;

    vga_draw_arbiter #(
        .N           (N),
        .COLOUR_W    (CW),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req      (req),
        .start    (start),
        .x_in     (x_in),
        .y_in     (y_in),
        .c_in     (c_in),
        .plot_in  (plot_in),
        .done_in  (done_in),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .grant    (grant),
        .busy     (busy),
        .job_done (job_done),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic wait_start();
        int waited = 0;
        while (start == '0 && waited < 8) begin
            tick();
            waited++;
        end
        check("start_seen", 32'(start != '0), 32'd1);
    endtask

    // One full job for module idx; done during START must be ignored,
    // and the final pixel coincides with done.
    task automatic run_job(input int idx, input bit intrude);
        wait_start();
        check("start_onehot", 32'(start), 32'(1) << idx);
        check("grant_start", 32'(grant), 32'(1) << idx);
        check("busy_start", 32'(busy), 32'd1);
        done_in = 4'(32'(1) << idx);
        tick();
        done_in = '0;
        check("start_single", 32'(start), 32'd0);
        check("grant_draw", 32'(grant), 32'(1) << idx);
        x_in[idx*8 +: 8] = 8'(40 + idx);
        plot_in = '0;
        if (intrude) begin
            plot_in[2]     = 1'b1;
            done_in[2]     = 1'b1;
            x_in[2*8 +: 8] = 8'd99;
        end
        tick();
        check("plot_gated", 32'(plot), 32'd0);
        check("x_owner", 32'(x), 32'(40 + idx));
        check("grant_hold", 32'(grant), 32'(1) << idx);
        check("no_early_done", 32'(job_done), 32'd0);
        plot_in = '0;
        done_in = '0;
        x_in[idx*8 +: 8]   = 8'(50 + idx);
        y_in[idx*7 +: 7]   = 7'(idx + 3);
        c_in[idx*CW +: CW] = 9'(idx * 5 + 1);
        plot_in[idx] = 1'b1;
        done_in[idx] = 1'b1;
        tick();
        check("last_plot", 32'(plot), 32'd1);
        check("last_x", 32'(x), 32'(50 + idx));
        check("last_y", 32'(y), 32'(idx + 3));
        check("last_colour", 32'(colour), 32'(idx * 5 + 1));
        check("job_done", 32'(job_done), 32'd1);
        check("grant_clear", 32'(grant), 32'd0);
        check("busy_finish", 32'(busy), 32'd1);
        plot_in = '0;
        done_in = '0;
        tick();
        check("job_done_pulse", 32'(job_done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("plot_idle", 32'(plot), 32'd0);
    endtask

    initial begin
        resetn  = 1'b0;
        req     = '0;
        plot_in = '0;
        done_in = '0;
        x_in    = '0;
        y_in    = '0;
        c_in    = '0;
        do_reset();

        // Reset state.
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_job_done", 32'(job_done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);

        // Single request: start lands on the first edge after req.
        req = 4'b0001;
        tick();
        check("t1_start_cycle", 32'(start), 32'd1);
        run_job(0, 1'b0);
        req = '0;
        tick();
        check("t1_stay_idle", 32'(busy), 32'd0);

        // All requesting from reset: 0,1,2,3,0; module 2 intrudes during job 1.
        do_reset();
        req = 4'b1111;
        run_job(0, 1'b0);
        run_job(1, 1'b1);
        run_job(2, 1'b0);
        run_job(3, 1'b0);
        run_job(0, 1'b0);
        req = '0;
        tick();

        // Reset mid-DRAW clears outputs at once and restores the pointer.
        req = 4'b0100;
        wait_start();
        check("t5_grant", 32'(grant), 32'd4);
        req = '0;
        tick();
        plot_in[2]     = 1'b1;
        x_in[2*8 +: 8] = 8'd77;
        tick();
        check("t5_plot", 32'(plot), 32'd1);
        check("t5_x", 32'(x), 32'd77);
        resetn = 1'b0;
        #1;
        check("t5_rst_grant", 32'(grant), 32'd0);
        check("t5_rst_plot", 32'(plot), 32'd0);
        check("t5_rst_x", 32'(x), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        plot_in = '0;
        tick();
        resetn = 1'b1;
        req    = 4'b0101;
        run_job(0, 1'b0);
        req = '0;
        tick();

        // No plot and no done from the owner.
        req = 4'b0010;
        wait_start();
        check("t6_grant", 32'(grant), 32'd2);
        req = '0;
        tick();
`ifdef ARB_TIMEOUT_EN
        repeat (15) tick();
        check("t6_no_timeout_yet", 32'(timeout), 32'd0);
        check("t6_grant_before", 32'(grant), 32'd2);
        tick();
        check("t6_timeout", 32'(timeout), 32'd1);
        check("t6_job_done", 32'(job_done), 32'd1);
        check("t6_grant_clear", 32'(grant), 32'd0);
        tick();
        check("t6_timeout_pulse", 32'(timeout), 32'd0);
        check("t6_busy_idle", 32'(busy), 32'd0);
`else
        repeat (40) tick();
        check("t6_grant_held", 32'(grant), 32'd2);
        check("t6_busy_held", 32'(busy), 32'd1);
        check("t6_timeout_low", 32'(timeout), 32'd0);
        done_in[1] = 1'b1;
        tick();
        done_in = '0;
        check("t6_job_done", 32'(job_done), 32'd1);
        check("t6_timeout_off", 32'(timeout), 32'd0);
        tick();
        check("t6_busy_idle", 32'(busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
